serial_subtractor: RTL

Bit-serial N-bit subtractor computing {Bout, Diff} = A − B − Bin. It is the borrow-propagating counterpart of the team's combinational ripple-carry adder. It trades area for latency by resolving one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. Operands are accepted and results delivered over valid/ready handshakes, so the block drops into the same datapaths as the adder with a streaming interface.

---
 rtl/serial_subtractor.sv | 92 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: {Bout, Diff} = A - B - Bin, resolved LSB first through
// one full-subtractor cell and a borrow flop, with valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  diff_reg;
    logic          borrow;
    logic          d;
    logic          borrow_nxt;
    logic [N-1:0]  diff_nxt;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d          = a_reg[0] ^ b_reg[0] ^ borrow;
        borrow_nxt = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);
        diff_nxt   = {d, diff_reg[N-1:1]};
    end

    assign in_ready = (state == IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values of its neighbours, which the shift chains depend on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            diff_reg  <= '0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        borrow   <= Bin;
                        count    <= '0;
                        diff_reg <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_reg    <= a_reg >> 1;
                    b_reg    <= b_reg >> 1;
                    diff_reg <= diff_nxt;
                    borrow   <= borrow_nxt;
                    count    <= count + CW'(1);
                    // Final bit: publish the result straight into the output registers.
                    if (count == CW'(N - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Diff      <= diff_nxt;
                        Bout      <= borrow_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
